// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: sequencer for the EX-stage multiply/divide resources.
// Accepts one MULT/MULTU/DIV/DIVU request at a time, latches the operands,
// drives the shared mul and div units, stalls the pipeline until the 64-bit
// result is available, then emits a single-cycle HI/LO write.
//
// State table:
//   IDLE     | no operation in flight; accepts req_valid & ~flush
//   MUL_WAIT | operands on mul unit, counting up to MUL_LATENCY
//   DIV_WAIT | div_start held, waiting for the div_ready pulse
//   DONE     | hilo_we strobe with the captured result, then back to IDLE
//
// Ports:
//   clk, resetn                  clock, async active-low reset
//   flush                        abandon current/in-flight operation
//   req_valid/req_op/req_src1/2  md instruction from EX (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   stallreq, busy               pipeline stall request, state != IDLE
//   hilo_we, hi_wdata, lo_wdata  HI/LO write strobe and data
//   mul_signed/ina/inb, mul_result              multiplier interface
//   div_start/annul/signed/opdata1/2, div_result, div_ready   divider interface
module md_issue_ctrl #(
    parameter int MUL_LATENCY = 1,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic        stallreq,
    output logic        busy,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_annul,
    output logic        div_signed,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    input  logic [63:0] div_result,
    input  logic        div_ready
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LATENCY);

    state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0] src1_q, src2_q;
    logic        signed_q;      // op[0]==0 selects the signed variant
    logic [63:0] result_q;

    logic accept;
    logic mul_hit;
    logic div_hit;

    assign accept  = (state == IDLE) && req_valid && !flush;
    assign mul_hit = (state == MUL_WAIT) && !flush && (cnt == CNT_LAST);
    assign div_hit = (state == DIV_WAIT) && !flush && div_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            signed_q <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                src1_q   <= req_src1;
                src2_q   <= req_src2;
                signed_q <= ~req_op[0];
                cnt      <= CNT_W'(1);
            end else if ((state == MUL_WAIT) && !flush && !mul_hit) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (mul_hit) begin
                result_q <= mul_result;
            end else if (div_hit) begin
                result_q <= div_result;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = req_op[1] ? DIV_WAIT : MUL_WAIT;
                end
            end
            MUL_WAIT: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (mul_hit) begin
                    state_nxt = DONE;
                end
            end
            DIV_WAIT: begin
                // flush wins over a coincident div_ready
                if (flush) begin
                    state_nxt = IDLE;
                end else if (div_ready) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // req_valid here is still the completed instruction: never restart
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stallreq    = 1'b0;
        busy        = (state != IDLE);
        hilo_we     = 1'b0;
        hi_wdata    = '0;
        lo_wdata    = '0;
        mul_signed  = 1'b0;
        mul_ina     = '0;
        mul_inb     = '0;
        div_start   = 1'b0;
        div_annul   = 1'b0;
        div_signed  = 1'b0;
        div_opdata1 = '0;
        div_opdata2 = '0;
        case (state)
            IDLE: begin
                // gated by resetn so nothing is requested while reset is held
                stallreq = req_valid && !flush && resetn;
            end
            MUL_WAIT: begin
                stallreq   = !flush;
                mul_signed = signed_q;
                mul_ina    = src1_q;
                mul_inb    = src2_q;
            end
            DIV_WAIT: begin
                stallreq    = !flush;
                div_start   = 1'b1;
                div_annul   = flush;
                div_signed  = signed_q;
                div_opdata1 = src1_q;
                div_opdata2 = src2_q;
            end
            DONE: begin
                hilo_we  = !flush;
                hi_wdata = flush ? 32'd0 : result_q[63:32];
                lo_wdata = flush ? 32'd0 : result_q[31:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
module tb_md_issue_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_src1, req_src2;
    logic        stallreq, busy, hilo_we;
    logic [31:0] hi_wdata, lo_wdata;
    logic        mul_signed;
    logic [31:0] mul_ina, mul_inb;
    logic [63:0] mul_result;
    logic        div_start, div_annul, div_signed;
    logic [31:0] div_opdata1, div_opdata2;
    logic [63:0] div_result;
    logic        div_ready;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    int div_lat = 33;
    int div_cnt = 0;
    int start_cycles = 0;

    md_issue_ctrl #(.MUL_LATENCY(1), .CNT_W(4)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .req_valid(req_valid), .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
        .stallreq(stallreq), .busy(busy), .hilo_we(hilo_we),
        .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
        .div_start(div_start), .div_annul(div_annul), .div_signed(div_signed),
        .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
        .div_result(div_result), .div_ready(div_ready)
    );

    always #5 clk = ~clk;

    // multiplier model: combinational product of the presented operands
    always @* begin
        if (mul_signed)
            mul_result = $signed({{32{mul_ina[31]}}, mul_ina}) * $signed({{32{mul_inb[31]}}, mul_inb});
        else
            mul_result = {32'd0, mul_ina} * {32'd0, mul_inb};
    end

    // divider model: result pulse after div_lat cycles of div_start
    always @(posedge clk) begin
        if (!div_start || div_annul) div_cnt <= 0;
        else                         div_cnt <= div_cnt + 1;
    end
    assign div_ready = div_start && (div_cnt == div_lat);

    always @* begin
        logic [31:0] q, r;
        q = 32'd0;
        r = 32'd0;
        if (div_opdata2 != 32'd0) begin
            if (div_signed) begin
                q = $signed(div_opdata1) / $signed(div_opdata2);
                r = $signed(div_opdata1) % $signed(div_opdata2);
            end else begin
                q = div_opdata1 / div_opdata2;
                r = div_opdata1 % div_opdata2;
            end
        end
        div_result = {r, q};
    end

    always @(negedge clk) if (div_start) start_cycles <= start_cycles + 1;

    // scoreboard monitor
    always @(negedge clk) begin
        if (hilo_we) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL hilo_unexpected got=%h_%h required=no write", hi_wdata, lo_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({hi_wdata, lo_wdata} !== e) begin
                    n_err++;
                    $display("FAIL hilo_data got=%h_%h required=%h_%h",
                             hi_wdata, lo_wdata, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
    endtask

    task automatic wait_we(input int max, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (hilo_we) begin
                hit = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!hit) begin
            n_err++;
            $display("FAIL %s_timeout got=no hilo_we required=hilo_we within %0d cycles", name, max);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=still running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0; flush = 1'b0;
        req_valid = 1'b1; req_op = 2'b00; req_src1 = 32'h1234; req_src2 = 32'h5;
        repeat (2) @(negedge clk);
        chk("rst_stallreq", stallreq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_outputs", {hilo_we, mul_signed, div_start, div_annul, div_signed}, 0);
        chk("rst_data", {hi_wdata, lo_wdata, mul_ina, div_opdata1}, 0);
        req_valid = 1'b0;
        step();
        resetn = 1'b1;
        step();

        // MULT -3 * 5
        issue(2'b00, 32'hFFFFFFFD, 32'd5);
        exp_q.push_back(64'hFFFFFFFF_FFFFFFF1);
        @(negedge clk);
        chk("mult_c0_stall", stallreq, 1);
        chk("mult_c0_busy", busy, 0);
        step();
        @(negedge clk);
        chk("mult_c1_stall", stallreq, 1);
        chk("mult_c1_signed", mul_signed, 1);
        chk("mult_c1_ops", {mul_ina, mul_inb}, {32'hFFFFFFFD, 32'd5});
        step();
        @(negedge clk);
        chk("mult_c2_we", hilo_we, 1);
        chk("mult_c2_stall", stallreq, 0);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("mult_c3_idle", {busy, hilo_we, hi_wdata, mul_ina}, 0);

        // DIVU 100 / 7
        step();
        start_cycles = 0;
        issue(2'b11, 32'd100, 32'd7);
        exp_q.push_back({32'd2, 32'd14});
        step();
        @(negedge clk);
        chk("divu_start", div_start, 1);
        chk("divu_signed", div_signed, 0);
        chk("divu_ops", {div_opdata1, div_opdata2}, {32'd100, 32'd7});
        chk("divu_mul_idle", mul_ina, 0);
        wait_we(60, "divu");
        chk("divu_done_stall", {stallreq, div_start}, 0);
        chk("divu_start_cycles", start_cycles, 34);
        step();
        req_valid = 1'b0;

        // DIV -7 / 2
        step();
        issue(2'b10, 32'hFFFFFFF9, 32'd2);
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
        step();
        @(negedge clk);
        chk("div_signed", div_signed, 1);
        wait_we(60, "div");
        step();
        req_valid = 1'b0;

        // flush during DIV_WAIT
        step();
        issue(2'b10, 32'd50, 32'd3);
        repeat (10) step();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_annul", div_annul, 1);
        chk("flush_stall", stallreq, 0);
        step();
        flush = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("flush_idle", {busy, div_annul, div_start}, 0);
        repeat (40) step();

        // flush in IDLE: request not taken
        issue(2'b00, 32'd3, 32'd3);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_stall", stallreq, 0);
        step();
        flush = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("flush_idle_noaccept", busy, 0);

        // flush in DONE suppresses the write
        step();
        issue(2'b01, 32'd9, 32'd9);
        step();
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_done_we", hilo_we, 0);
        step();
        flush = 1'b0;
        req_valid = 1'b0;
        repeat (3) step();

        // req_valid held through DONE, then back-to-back MULTU
        issue(2'b00, 32'd7, 32'd6);
        exp_q.push_back(64'd42);
        step();
        step();
        @(negedge clk);
        chk("held_done_we", hilo_we, 1);
        step();
        issue(2'b01, 32'hFFFFFFFF, 32'd2);
        exp_q.push_back(64'h00000001_FFFFFFFE);
        @(negedge clk);
        chk("b2b_accept", {busy, stallreq}, 2'b01);
        step();
        @(negedge clk);
        chk("b2b_unsigned", mul_signed, 0);
        step();
        @(negedge clk);
        chk("b2b_we", hilo_we, 1);
        step();
        req_valid = 1'b0;
        repeat (3) step();

        // reset in MUL_WAIT
        issue(2'b00, 32'd11, 32'd13);
        step();
        resetn = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rst_mid_outputs", {stallreq, busy, hilo_we, mul_signed}, 0);
        chk("rst_mid_data", {mul_ina, mul_inb, hi_wdata, lo_wdata}, 0);
        repeat (2) step();
        resetn = 1'b1;
        repeat (6) step();
        chk("rst_mid_idle", busy, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
